// File: rtl/matmul_ctrl.sv
// Sequencer for an X * A matrix product: walks (r, c, k), issues ROM/memory
// addresses, MAC accumulate/clear strobes and result writes, one element per N_K+2 cycles.
module matmul_ctrl #(
  parameter int N_K   = 8,
  parameter int N_ROW = 4,
  parameter int N_COL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       aload_done,
  output logic [4:0] a_addr,
  output logic [4:0] x_addr,
  output logic       mac_en,
  output logic       mac_clr,
  output logic       p_we,
  output logic [3:0] p_addr,
  output logic       busy,
  output logic       done
);

  localparam int KW = (N_K   > 1) ? $clog2(N_K)   : 1;
  localparam int RW = (N_ROW > 1) ? $clog2(N_ROW) : 1;
  localparam int CW = (N_COL > 1) ? $clog2(N_COL) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]    state;
  logic [KW-1:0] k;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [4:0]    a_calc, x_calc, a_hold, x_hold;

  assign a_calc = 5'(int'(c) * N_K + int'(k));
  assign x_calc = 5'(int'(r) * N_K + int'(k));

  // Addresses follow the counters during RUN and otherwise hold the last issued pair.
  assign a_addr = (state == S_RUN) ? a_calc : a_hold;
  assign x_addr = (state == S_RUN) ? x_calc : x_hold;
  assign p_addr = 4'(int'(r) * N_COL + int'(c));
  assign p_we   = (state == S_WRITE);
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      k       <= '0;
      r       <= '0;
      c       <= '0;
      a_hold  <= '0;
      x_hold  <= '0;
      mac_en  <= 1'b0;
      mac_clr <= 1'b0;
    end else begin
      // One-cycle read latency: the strobe trails the address by a cycle.
      mac_en  <= (state == S_RUN);
      mac_clr <= (state == S_RUN) && (k == '0);
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= aload_done ? S_RUN : S_WAIT;
            k <= '0;
            r <= '0;
            c <= '0;
          end
        end
        S_WAIT: begin
          if (aload_done) begin
            state <= S_RUN;
            k <= '0;
            r <= '0;
            c <= '0;
          end
        end
        S_RUN: begin
          a_hold <= a_calc;
          x_hold <= x_calc;
          if (k == KW'(N_K - 1)) state <= S_DRAIN;
          else                   k <= k + 1'b1;
        end
        S_DRAIN: state <= S_WRITE;
        S_WRITE: begin
          k <= '0;
          if (c < CW'(N_COL - 1)) begin
            c     <= c + 1'b1;
            state <= S_RUN;
          end else if (r < RW'(N_ROW - 1)) begin
            c     <= '0;
            r     <= r + 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_FIN;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl: full products, delayed coefficient load,
// mid-run reset, start-during-reset and start-while-busy.
module tb_matmul_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, aload_done;
  logic [4:0] a_addr, x_addr;
  logic       mac_en, mac_clr, p_we, busy, done;
  logic [3:0] p_addr;

  int checks = 0;
  int errors = 0;

  matmul_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .aload_done(aload_done),
    .a_addr(a_addr), .x_addr(x_addr), .mac_en(mac_en), .mac_clr(mac_clr),
    .p_we(p_we), .p_addr(p_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".outs"}, {a_addr, x_addr, mac_en, mac_clr, p_we, p_addr, busy, done}, 32'd0);
  endtask

  // Entered at the negedge of the first RUN cycle. Cycle n belongs to element
  // e = n/10 at phase p = n%10: phases 0..7 RUN, 8 DRAIN, 9 WRITE.
  // noisy: toggle start and drop aload_done mid-run. rst_at >= 0: reset there and return.
  task automatic run_check(input string tag, input bit noisy, input int rst_at);
    int wr = 0;
    int e, p, rr, cc, ka;
    for (int n = 0; n < 160; n++) begin
      e  = n / 10;
      p  = n % 10;
      rr = e / 4;
      cc = e % 4;
      ka = (p < 8) ? p : 7;
      chk({tag, ".busy"},    busy,    1);
      chk({tag, ".a_addr"},  a_addr,  cc * 8 + ka);
      chk({tag, ".x_addr"},  x_addr,  rr * 8 + ka);
      chk({tag, ".mac_en"},  mac_en,  (p >= 1 && p <= 8));
      chk({tag, ".mac_clr"}, mac_clr, (p == 1));
      chk({tag, ".p_we"},    p_we,    (p == 9));
      chk({tag, ".done"},    done,    0);
      if (p == 9) begin
        chk({tag, ".p_addr"}, p_addr, e);
        wr++;
      end
      if (n == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_zero({tag, ".midrst"});
        return;
      end
      start = noisy && (n % 13 == 4);
      if (noisy) aload_done = (n < 40);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, ".writes"},   wr,   16);
    chk({tag, ".fin_done"}, done, 1);
    chk({tag, ".fin_busy"}, busy, 1);
    chk({tag, ".fin_pwe"},  p_we, 0);
    @(negedge clk);
    chk({tag, ".post_done"}, done, 0);
    chk({tag, ".post_busy"}, busy, 0);
    aload_done = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; aload_done = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Plain full product.
    pulse_start();
    run_check("run1", 1'b0, -1);

    // Delayed coefficient load; extra start pulses while waiting.
    aload_done = 1'b0;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      chk("wait.busy",   busy,   1);
      chk("wait.mac_en", mac_en, 0);
      chk("wait.p_we",   p_we,   0);
      start = (i == 7);
      @(negedge clk);
    end
    start = 1'b0;
    aload_done = 1'b1;
    @(negedge clk);
    run_check("wait_run", 1'b0, -1);

    // Reset at element 5, k=3, then a clean full product.
    pulse_start();
    run_check("rst_run", 1'b0, 53);
    @(negedge clk);
    chk("rst_idle", busy, 0);
    pulse_start();
    run_check("after_rst", 1'b0, -1);

    // Start coincident with reset is discarded.
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk_idle_zero("rst_start");
    @(negedge clk);
    chk("rst_start.busy", busy, 0);

    // Start pulses and aload_done drop during a run change nothing.
    pulse_start();
    run_check("noisy", 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
